// File: rtl/shreg_pkg.sv
// Shared mode encoding for the universal shift register.
package shreg_pkg;

  typedef logic [1:0] shreg_mode_t;

  localparam shreg_mode_t MODE_HOLD = 2'b00;
  localparam shreg_mode_t MODE_SHL  = 2'b01;
  localparam shreg_mode_t MODE_SHR  = 2'b10;
  localparam shreg_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered at-max flag.
module sat_counter #(
  parameter int CNT_W = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             at_max_d, at_max_q;

  // at_max follows the next count so it lands on the same edge as cnt.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    at_max_d = (cnt_d == MAX_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      at_max_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      at_max_q <= at_max_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = at_max_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift left / shift right / parallel load.
// Define UNIV_SHIFT_REG_ROTATE_EN to add the rot input (rotate instead of serial fill).
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             drained
);

  shreg_mode_t      mode_s;
  logic [WIDTH-1:0] q_d, q_q;
  logic             shl_in, shr_in;
  logic             do_shift, do_load;

  assign mode_s   = shreg_mode_t'(mode);
  assign do_shift = en && ((mode_s == MODE_SHL) || (mode_s == MODE_SHR));
  assign do_load  = en && (mode_s == MODE_LOAD);

  // Fill bits come from the serial pins, or from the opposite end when rotating.
  always_comb begin
    shl_in = sin_l;
    shr_in = sin_r;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    if (rot) begin
      shl_in = q_q[WIDTH-1];
      shr_in = q_q[0];
    end
`endif
  end

  // Shifts are written via a WIDTH+1 concatenation so WIDTH=1 needs no special case.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode_s)
        MODE_SHL:  q_d = WIDTH'({q_q, shl_in});
        MODE_SHR:  q_d = WIDTH'({shr_in, q_q} >> 1);
        MODE_LOAD: q_d = pdata;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W),
    .MAX   (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (do_load),
    .inc    (do_shift),
    .cnt    (shift_cnt),
    .at_max (drained)
  );

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised and directed bench for univ_shift_reg (8-bit, 8-bit with RST_VAL=5A, 1-bit).
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, en, sin_l, sin_r, rot;
  logic [1:0] mode;
  logic [7:0] pdata;

  logic [7:0] q_a, q_b;
  logic       sl_a, sr_a, sl_b, sr_b, dr_a, dr_b;
  logic [3:0] cnt_a, cnt_b;
  logic [0:0] q_w;
  logic       sl_w, sr_w, dr_w;
  logic [0:0] cnt_w;

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  int m_qa, m_qb, m_c8, m_qw, m_c1;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot(rot),
`endif
    .sin_l(sin_l), .sin_r(sin_r), .pdata(pdata),
    .q(q_a), .sout_l(sl_a), .sout_r(sr_a), .shift_cnt(cnt_a), .drained(dr_a)
  );

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h5A)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot(rot),
`endif
    .sin_l(sin_l), .sin_r(sin_r), .pdata(pdata),
    .q(q_b), .sout_l(sl_b), .sout_r(sr_b), .shift_cnt(cnt_b), .drained(dr_b)
  );

  univ_shift_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_dut_w (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot(rot),
`endif
    .sin_l(sin_l), .sin_r(sin_r), .pdata(pdata[0:0]),
    .q(q_w), .sout_l(sl_w), .sout_r(sr_w), .shift_cnt(cnt_w), .drained(dr_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int c, input int w);
    return (c < w) ? c + 1 : w;
  endfunction

  // Reference: registers as integers, shifts as multiply/divide by two.
  task automatic model_step();
    bit ro;
    int fa, fb;
    ro = ROT_ON && rot;
    if (rst) begin
      m_qa = 0; m_qb = 'h5A; m_c8 = 0; m_qw = 0; m_c1 = 0;
    end else if (en) begin
      case (mode)
        2'b01: begin
          fa = ro ? m_qa / 128 : int'(sin_l);
          fb = ro ? m_qb / 128 : int'(sin_l);
          m_qa = (m_qa * 2) % 256 + fa;
          m_qb = (m_qb * 2) % 256 + fb;
          m_qw = ro ? m_qw : int'(sin_l);
          m_c8 = sat_inc(m_c8, 8);
          m_c1 = sat_inc(m_c1, 1);
        end
        2'b10: begin
          fa = ro ? m_qa % 2 : int'(sin_r);
          fb = ro ? m_qb % 2 : int'(sin_r);
          m_qa = m_qa / 2 + fa * 128;
          m_qb = m_qb / 2 + fb * 128;
          m_qw = ro ? m_qw : int'(sin_r);
          m_c8 = sat_inc(m_c8, 8);
          m_c1 = sat_inc(m_c1, 1);
        end
        2'b11: begin
          m_qa = int'(pdata); m_qb = int'(pdata); m_qw = int'(pdata[0]);
          m_c8 = 0; m_c1 = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("a_q", q_a, m_qa);
    chk("a_sout_l", sl_a, m_qa / 128);
    chk("a_sout_r", sr_a, m_qa % 2);
    chk("a_cnt", cnt_a, m_c8);
    chk("a_drained", dr_a, m_c8 == 8);
    chk("b_q", q_b, m_qb);
    chk("b_cnt", cnt_b, m_c8);
    chk("b_drained", dr_b, m_c8 == 8);
    chk("w_q", q_w, m_qw);
    chk("w_sout", {sl_w, sr_w}, {m_qw[0], m_qw[0]});
    chk("w_cnt", cnt_w, m_c1);
    chk("w_drained", dr_w, m_c1 == 1);
  endtask

  task automatic drive(input bit r, input bit e, input bit [1:0] m, input bit sl,
                       input bit sr, input bit [7:0] pd, input bit ro);
    rst = r; en = e; mode = m; sin_l = sl; sin_r = sr; pdata = pd; rot = ro;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; sin_l = 1'b0; sin_r = 1'b0;
    pdata = 8'h00; rot = 1'b0;
    m_qa = 0; m_qb = 'h5A; m_c8 = 0; m_qw = 0; m_c1 = 0;
    #2;

    // reset overrides a simultaneous load
    drive(1, 1, 2'b11, 0, 0, 8'hFF, 0);
    chk("t1_q", q_a, 8'h00);
    chk("t1_cnt", cnt_a, 0);
    chk("t1_drained", dr_a, 0);

    // load then shift left with ones
    drive(0, 1, 2'b11, 0, 0, 8'hA5, 0);
    chk("t2_sout_l0", sl_a, 1);
    drive(0, 1, 2'b01, 1, 0, 8'h00, 0);
    chk("t2_sout_l1", sl_a, 0);
    drive(0, 1, 2'b01, 1, 0, 8'h00, 0);
    chk("t2_sout_l2", sl_a, 1);
    drive(0, 1, 2'b01, 1, 0, 8'h00, 0);
    chk("t2_q", q_a, 8'h2F);
    chk("t2_cnt", cnt_a, 3);

    // drain right, then one extra shift past saturation
    drive(0, 1, 2'b11, 0, 0, 8'h81, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, 2'b10, 0, 0, 8'h00, 0);
    chk("t3_drained_early", dr_a, 0);
    drive(0, 1, 2'b10, 0, 0, 8'h00, 0);
    chk("t3_q", q_a, 8'h00);
    chk("t3_cnt", cnt_a, 8);
    chk("t3_drained", dr_a, 1);
    drive(0, 1, 2'b10, 0, 0, 8'h00, 0);
    chk("t3_cnt_sat", cnt_a, 8);

    // enable gating, including pdata changes while disabled
    drive(0, 1, 2'b11, 0, 0, 8'h3C, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 2'b01, 1, 1, 8'(i * 17), 0);
    drive(0, 0, 2'b11, 1, 1, 8'hEE, 0);
    chk("t4_q", q_a, 8'h3C);
    chk("t4_cnt", cnt_a, 0);

    // reset mid-stream on the RST_VAL=5A instance
    drive(0, 1, 2'b11, 0, 0, 8'hF0, 0);
    drive(0, 1, 2'b01, 1, 0, 8'h00, 0);
    drive(0, 1, 2'b01, 0, 0, 8'h00, 0);
    drive(1, 1, 2'b01, 1, 0, 8'h00, 0);
    chk("t5_q", q_b, 8'h5A);
    chk("t5_cnt", cnt_b, 0);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    drive(0, 1, 2'b11, 0, 0, 8'h81, 0);
    drive(0, 1, 2'b01, 0, 0, 8'h00, 1);
    chk("t6_q_rotl", q_a, 8'h03);
    chk("t6_cnt", cnt_a, 1);
    drive(0, 1, 2'b10, 0, 0, 8'h00, 1);
    chk("t6_q_rotr", q_a, 8'h81);
    for (int i = 0; i < 7; i++) drive(0, 1, 2'b10, 0, 0, 8'h00, 1);
    chk("t6_drained", dr_a, 1);
    chk("t6_q_final", q_a, 8'h03);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 40) == 0, ($urandom % 4) != 0, 2'($urandom),
            1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
